// File: rtl/seq_scan_arbiter_if.sv
// Source-side bundle for the four-way serial pattern-scan arbiter.
// Sources drive request, serial data and pattern config; status and grant flow back.
interface seq_scan_arbiter_if #(
  parameter int CNT_W = 8
);
  logic [3:0]       req;
  logic [3:0]       x_in;
  logic             cfg_we;
  logic [3:0]       cfg_pat;
  logic [2:0]       cfg_len;
  logic [3:0]       gnt;
  logic             busy;
  logic             hit;
  logic [1:0]       hit_id;
  logic [CNT_W-1:0] hit_cnt;
  logic             done;
  logic             abort;

  modport master (
    output req, x_in, cfg_we, cfg_pat, cfg_len,
    input  gnt, busy, hit, hit_id, hit_cnt, done, abort
  );

  modport slave (
    input  req, x_in, cfg_we, cfg_pat, cfg_len,
    output gnt, busy, hit, hit_id, hit_cnt, done, abort
  );
endinterface

// File: rtl/seq_scan_arbiter.sv
// Round-robin share of one overlapping serial pattern recognizer; grant 1 cycle after req, frame = FRAME_LEN+3 cycles.
// No backpressure: a granted source must hold req for the frame, dropping it aborts the frame.
module seq_scan_arbiter #(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset_,
  seq_scan_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_SCAN,
    ST_DONE
  } state_t;

  localparam logic [8:0] FRAME_LAST = 9'(FRAME_LEN);

  state_t           state_q;
  logic [3:0]       gnt_q;
  logic             hit_q;
  logic [1:0]       hit_id_q;
  logic [CNT_W-1:0] hit_cnt_q;
  logic             done_q;
  logic             abort_q;
  logic [3:0]       pat_q;
  logic [2:0]       len_q;
  logic [1:0]       rr_ptr_q;
  // Only three history bits are kept; the fourth comes from the incoming bit.
  logic [2:0]       shift_q;
  logic [7:0]       bit_cnt_q;

  logic             sel_vld;
  logic [1:0]       sel_idx;
  logic [3:0]       shift_d;
  logic [8:0]       bit_cnt_d;
  logic [3:0]       len_mask;
  logic             match_d;
  logic             cfg_ok;
  logic [CNT_W-1:0] hit_cnt_d;

  // Lowest offset from rr_ptr wins, so iterate from the far end down.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = rr_ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[rr_ptr_q + 2'(k)]) begin
        sel_vld = 1'b1;
        sel_idx = rr_ptr_q + 2'(k);
      end
    end
  end

  always_comb begin
    case (len_q)
      3'd1:    len_mask = 4'b0001;
      3'd2:    len_mask = 4'b0011;
      3'd3:    len_mask = 4'b0111;
      default: len_mask = 4'b1111;
    endcase
  end

  assign shift_d   = {shift_q, bus.x_in[hit_id_q]};
  assign bit_cnt_d = {1'b0, bit_cnt_q} + 9'd1;
  assign match_d   = (bit_cnt_d >= {6'd0, len_q}) &&
                     ((shift_d & len_mask) == (pat_q & len_mask));
  assign cfg_ok    = bus.cfg_we && (bus.cfg_len != 3'd0) && (bus.cfg_len <= 3'd4);
  assign hit_cnt_d = (&hit_cnt_q) ? hit_cnt_q : hit_cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 4'b0000;
      hit_q     <= 1'b0;
      hit_id_q  <= 2'd0;
      hit_cnt_q <= '0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      pat_q     <= 4'b0010;
      len_q     <= 3'd4;
      rr_ptr_q  <= 2'd0;
      shift_q   <= 3'd0;
      bit_cnt_q <= 8'd0;
    end else begin
      hit_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cfg_ok) begin
            pat_q <= bus.cfg_pat;
            len_q <= bus.cfg_len;
          end
          if (sel_vld) begin
            gnt_q    <= 4'b0001 << sel_idx;
            hit_id_q <= sel_idx;
            rr_ptr_q <= sel_idx + 2'd1;
            state_q  <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          shift_q   <= 3'd0;
          bit_cnt_q <= 8'd0;
          hit_cnt_q <= '0;
          abort_q   <= 1'b0;
          state_q   <= ST_SCAN;
        end
        ST_SCAN: begin
          if (bus.req[hit_id_q]) begin
            shift_q   <= shift_d[2:0];
            bit_cnt_q <= bit_cnt_d[7:0];
            if (match_d) begin
              hit_q     <= 1'b1;
              hit_cnt_q <= hit_cnt_d;
            end
            if (bit_cnt_d == FRAME_LAST) begin
              gnt_q   <= 4'b0000;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end else begin
            abort_q <= 1'b1;
            gnt_q   <= 4'b0000;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.hit     = hit_q;
  assign bus.hit_id  = hit_id_q;
  assign bus.hit_cnt = hit_cnt_q;
  assign bus.done    = done_q;
  assign bus.abort   = abort_q;

endmodule
